axinpkt_fifo: RTL

//  Single-clock store-and-forward packet FIFO for the switch's AXI network streams.

---
 rtl/axinpkt_fifo_if.sv | 17 +
 rtl/axinpkt_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/axinpkt_fifo_if.sv
// AXI-style packet stream bundle: valid/ready handshake plus data, byte count, last and abort.
// The master drives the beat; the slave answers with ready.
interface axinpkt_fifo_if #(
  parameter int DW = 64
);
  localparam int BW = $clog2(DW / 8);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [BW-1:0] bytes;
  logic          abort;
  logic          last;

  modport master (output valid, data, bytes, abort, last, input ready);
  modport slave  (input valid, data, bytes, abort, last, output ready);
endinterface

// File: rtl/axinpkt_fifo.sv
// Store-and-forward packet FIFO: a packet becomes visible downstream only once its LAST beat is written;
// aborted or over-length packets are rewound away. Optional AXINPKT_STATS_EN adds packet/drop counters.
module axinpkt_fifo #(
  parameter int DW     = 64,
  parameter int LGFIFO = 9
) (
  input  logic           i_clk,
  input  logic           i_reset,
  axinpkt_fifo_if.slave  s_axis,
  axinpkt_fifo_if.master m_axis
`ifdef AXINPKT_STATS_EN
  ,
  output logic [31:0]    o_pkt_count,
  output logic [31:0]    o_drop_count
`endif
);
  localparam int BW     = $clog2(DW / 8);
  localparam int AW     = LGFIFO + 1;
  localparam int DEPTHN = 1 << LGFIFO;
  localparam logic [AW-1:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MID, ST_DROP} wr_state_t;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] bytes;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         mem [DEPTHN];

  wr_state_t     state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] wr_commit_q, wr_commit_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          m_valid_q, m_valid_d;
  beat_t         m_beat_q, m_beat_d;

  logic          full;
  logic          pkt_full;
  logic          wr_en;
  logic          rd_en;
  beat_t         s_beat;

  assign s_beat   = {s_axis.last, s_axis.bytes, s_axis.data};
  assign full     = (wr_addr_q - rd_addr_q) == DEPTH;
  assign pkt_full = (wr_addr_q - wr_commit_q) == DEPTH;

  // An over-length packet fills the buffer by itself, so its next beat must still be taken
  // or the writer would deadlock instead of dropping it.
  assign s_axis.ready = s_axis.abort || (state_q == ST_DROP) || !full || pkt_full;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_axis.valid && !s_axis.abort && !full) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (s_axis.last) begin
            wr_commit_d = wr_addr_q + 1'b1;
          end else begin
            state_d = ST_MID;
          end
        end
      end
      ST_MID: begin
        if (s_axis.abort) begin
          wr_addr_d = wr_commit_q;
          state_d   = ST_IDLE;
        end else if (s_axis.valid) begin
          if (pkt_full) begin
            if (s_axis.last) begin
              wr_addr_d = wr_commit_q;
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end else if (!full) begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
            if (s_axis.last) begin
              wr_commit_d = wr_addr_q + 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (s_axis.abort || (s_axis.valid && s_axis.last)) begin
          wr_addr_d = wr_commit_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register doubles as the registered memory read; refill whenever it empties or drains.
  always_comb begin
    rd_en     = (rd_addr_q != wr_commit_q) && (!m_valid_q || m_axis.ready);
    rd_addr_d = rd_en ? (rd_addr_q + 1'b1) : rd_addr_q;
    m_valid_d = rd_en || (m_valid_q && !m_axis.ready);
    m_beat_d  = rd_en ? mem[rd_addr_q[LGFIFO-1:0]] : m_beat_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      wr_commit_q <= '0;
      rd_addr_q   <= '0;
      m_valid_q   <= 1'b0;
      m_beat_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_commit_q <= wr_commit_d;
      rd_addr_q   <= rd_addr_d;
      m_valid_q   <= m_valid_d;
      m_beat_q    <= m_beat_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr_q[LGFIFO-1:0]] <= s_beat;
    end
  end

  assign m_axis.valid = m_valid_q;
  assign m_axis.data  = m_beat_q.data;
  assign m_axis.bytes = m_beat_q.bytes;
  assign m_axis.last  = m_beat_q.last;
  assign m_axis.abort = 1'b0;

`ifdef AXINPKT_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        commit_ev;
  logic        drop_ev;

  // Every commit advances wr_commit; every other return to IDLE from MID/DROP is a drop.
  assign commit_ev = (wr_commit_d != wr_commit_q);
  assign drop_ev   = (state_q != ST_IDLE) && (state_d == ST_IDLE) && !commit_ev;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + 32'(commit_ev);
    drop_cnt_d = drop_cnt_q + 32'(drop_ev);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_pkt_count  = pkt_cnt_q;
  assign o_drop_count = drop_cnt_q;
`endif
endmodule
